fft4_rr_sched: RTL
==================

Name: fft4_rr_sched

Overview:
- Round-robin scheduler that shares one fft4 pipeline among N_REQ frame producers.
- Each requester offers a 4-sample complex frame through a valid/ready handshake. The scheduler grants at most one frame per cycle and drives the fft4 inputs and i_valid.
- A tag pipeline of the fixed fft4 latency routes each result back with the originating requester id.
- The block sits between the frame buffers and the fft4 instance; it owns fft4 reset and enable.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- NB_INPUT, 8, bits per real/imag input component (matches fft4 NB_INPUT).
- NB_OUTPUT, 10, bits per real/imag output component (matches fft4 NB_OUTPUT).
- FFT_LATENCY, 4, cycles from fft4 i_valid to o_valid.
- NB_CNT, 16, width of issued-frame counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_enable  in  1  scheduler enable; 0 stops new grants, in-flight frames still drain.
- i_req_valid  in  N_REQ  per-requester frame valid.
- i_req_data  in  N_REQ*8*NB_INPUT  requester k frame at bits [k*8*NB_INPUT +: 8*NB_INPUT]; packed {x3,x2,x1,x0}, each x = {re,im}.
- o_req_ready  out  N_REQ  one-hot grant; handshake when valid&ready.
- o_fft_x0..o_fft_x3  out  2*NB_INPUT each  frame to fft4 i_x0..i_x3.
- o_fft_valid  out  1  to fft4 i_valid.
- o_fft_rst  out  1  to fft4 i_rst (active-high).
- i_fft_valid  in  1  from fft4 o_valid.
- i_fft_x0..i_fft_x3  in  2*NB_OUTPUT each  from fft4 o_x0..o_x3.
- o_res_valid  out  1  result frame valid (no backpressure).
- o_res_id  out  clog2(N_REQ)  requester id of result.
- o_res_data  out  8*NB_OUTPUT  {x3,x2,x1,x0} of result.
- o_busy  out  1  high while any frame is in flight.
- o_err  out  1  sticky tag/valid mismatch flag.
- o_frame_cnt  out  NB_CNT  total frames issued, wraps.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - o_req_ready=0, o_fft_valid=0, o_fft_x*=0, o_res_valid=0, o_res_id=0, o_res_data=0, o_err=0, o_busy=0, o_frame_cnt=0.
  - Round-robin pointer=0; tag pipeline cleared.
  - o_fft_rst = ~i_rst_n, combinational.
- Reset mid-operation: in-flight frames are discarded; no o_res_valid for them.
- Arbitration (combinational):
  - When i_enable=1, grant the first requester with i_req_valid=1, searching from pointer upward with wrap.
  - o_req_ready is one-hot for that requester; all zero if i_enable=0 or no valid request.
  - o_req_ready never depends on o_req_ready.
- Pointer update: on a handshake with requester k, pointer <= (k+1) mod N_REQ. Unchanged otherwise.
- Issue: a handshake at edge t loads o_fft_x* from the granted frame and sets o_fft_valid=1 at t+1, otherwise o_fft_valid=0. o_fft_x* hold their value when no issue.
- Back-to-back grants: allowed every cycle (fft4 is fully pipelined).
- Tag pipeline:
  - FFT_LATENCY-deep shift register of {valid,id}; its input is {o_fft_valid, issued id}.
  - The output entry aligns with i_fft_valid.
- Result: on i_fft_valid=1, register o_res_valid=1, o_res_id=tag id, o_res_data={i_fft_x3..x0} on the next edge. Otherwise o_res_valid=0 and data/id hold.
  - Total latency: handshake edge t -> o_res_valid at t+FFT_LATENCY+2.
- Error: i_fft_valid differing from tag-pipeline valid sets o_err=1 until reset. On i_fft_valid=1 the result is still emitted using the tag id.
- o_busy = OR of o_fft_valid and all tag-pipeline valid bits, registered.
- o_frame_cnt increments by 1 per handshake; wraps 2^NB_CNT-1 -> 0.
- Simultaneous events: issue and result in the same cycle are independent. i_enable falling in a cycle blocks that cycle's grant.

Test Plan:
- Single request: reset, then req1 valid with frame x0=x1=x2=x3={0x40,0x00}. Required: ready[1] the same cycle, o_fft_valid one cycle later, o_res_valid at t+6 with o_res_id=1, o_frame_cnt=1.
- Round-robin fairness: all 4 requesters valid continuously for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; o_res_id follows the same order on consecutive cycles.
- Pointer wrap and skip: pointer=3, only req0 and req2 valid. Required: req0 granted, then req2.
- Enable gating: i_enable=0 with all requests valid. Required: o_req_ready=0 and no o_fft_valid. Frames in flight still produce results, and o_busy falls after the drain.
- Reset mid-flight: assert i_rst_n=0 for 1 cycle 2 cycles after 3 issues. Required: no o_res_valid afterwards, o_err=0, o_frame_cnt=0, o_fft_rst=1 during reset.
- Mismatch: inject i_fft_valid=1 with an empty tag pipeline. Required: o_err=1 sticky and o_res_valid=1 the next cycle.

Source files
------------

// File: rtl/fft4_rr_sched.sv
// fft4_rr_sched: round-robin arbiter that shares one fft4 pipeline among
// N_REQ frame producers. A tag pipeline matching the fft4 latency carries the
// requester id alongside each frame so results are returned to their owner.
module fft4_rr_sched #(
    parameter int N_REQ       = 4,
    parameter int NB_INPUT    = 8,
    parameter int NB_OUTPUT   = 10,
    parameter int FFT_LATENCY = 4,
    parameter int NB_CNT      = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ*8*NB_INPUT-1:0]   i_req_data,
    output logic [N_REQ-1:0]              o_req_ready,
    output logic [2*NB_INPUT-1:0]         o_fft_x0,
    output logic [2*NB_INPUT-1:0]         o_fft_x1,
    output logic [2*NB_INPUT-1:0]         o_fft_x2,
    output logic [2*NB_INPUT-1:0]         o_fft_x3,
    output logic                          o_fft_valid,
    output logic                          o_fft_rst,
    input  logic                          i_fft_valid,
    input  logic [2*NB_OUTPUT-1:0]        i_fft_x0,
    input  logic [2*NB_OUTPUT-1:0]        i_fft_x1,
    input  logic [2*NB_OUTPUT-1:0]        i_fft_x2,
    input  logic [2*NB_OUTPUT-1:0]        i_fft_x3,
    output logic                          o_res_valid,
    output logic [$clog2(N_REQ)-1:0]      o_res_id,
    output logic [8*NB_OUTPUT-1:0]        o_res_data,
    output logic                          o_busy,
    output logic                          o_err,
    output logic [NB_CNT-1:0]             o_frame_cnt
);
    localparam int IDW = $clog2(N_REQ);
    localparam int FW  = 8*NB_INPUT;
    localparam int XW  = 2*NB_INPUT;

    logic [IDW-1:0]         ptr_q, ptr_d;
    logic                   gnt_found;
    logic [IDW-1:0]         gnt_id;
    logic                   hs;
    logic [FW-1:0]          gnt_frame;
    logic [FW-1:0]          fft_x_q, fft_x_d;
    logic                   fft_vld_q;
    logic [IDW-1:0]         issue_id_q, issue_id_d;
    logic [FFT_LATENCY-1:0] tag_vld_q;
    logic [IDW-1:0]         tag_id_q [FFT_LATENCY];
    logic                   res_vld_q;
    logic [IDW-1:0]         res_id_q, res_id_d;
    logic [8*NB_OUTPUT-1:0] res_data_q, res_data_d;
    logic                   busy_q;
    logic                   err_q, err_d;
    logic [NB_CNT-1:0]      cnt_q, cnt_d;

    // Search for the first valid requester starting at the pointer, with wrap.
    always_comb begin
        logic [IDW-1:0] idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % N_REQ);
            if (!gnt_found && i_req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    // Grant is suppressed while disabled or held in reset.
    assign hs        = i_enable & i_rst_n & gnt_found;
    assign gnt_frame = i_req_data[int'(gnt_id)*FW +: FW];

    // One-hot ready for the winning requester.
    always_comb begin
        o_req_ready = '0;
        if (hs) o_req_ready[gnt_id] = 1'b1;
    end

    // Next-state for pointer, issue registers, counter, error and result.
    always_comb begin
        ptr_d      = ptr_q;
        fft_x_d    = fft_x_q;
        issue_id_d = issue_id_q;
        cnt_d      = cnt_q;
        if (hs) begin
            ptr_d      = (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
            fft_x_d    = gnt_frame;
            issue_id_d = gnt_id;
            cnt_d      = cnt_q + 1'b1;
        end
        err_d      = err_q | (i_fft_valid != tag_vld_q[FFT_LATENCY-1]);
        res_id_d   = i_fft_valid ? tag_id_q[FFT_LATENCY-1] : res_id_q;
        res_data_d = i_fft_valid ? {i_fft_x3, i_fft_x2, i_fft_x1, i_fft_x0} : res_data_q;
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            fft_x_q    <= '0;
            fft_vld_q  <= 1'b0;
            issue_id_q <= '0;
            tag_vld_q  <= '0;
            for (int i = 0; i < FFT_LATENCY; i++) tag_id_q[i] <= '0;
            res_vld_q  <= 1'b0;
            res_id_q   <= '0;
            res_data_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ptr_q        <= ptr_d;
            fft_x_q      <= fft_x_d;
            fft_vld_q    <= hs;
            issue_id_q   <= issue_id_d;
            tag_vld_q[0] <= fft_vld_q;
            tag_id_q[0]  <= issue_id_q;
            for (int i = 1; i < FFT_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            res_vld_q  <= i_fft_valid;
            res_id_q   <= res_id_d;
            res_data_q <= res_data_d;
            busy_q     <= fft_vld_q | (|tag_vld_q);
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_fft_x0    = fft_x_q[0*XW +: XW];
    assign o_fft_x1    = fft_x_q[1*XW +: XW];
    assign o_fft_x2    = fft_x_q[2*XW +: XW];
    assign o_fft_x3    = fft_x_q[3*XW +: XW];
    assign o_fft_valid = fft_vld_q;
    assign o_fft_rst   = ~i_rst_n;
    assign o_res_valid = res_vld_q;
    assign o_res_id    = res_id_q;
    assign o_res_data  = res_data_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;
    assign o_frame_cnt = cnt_q;

endmodule
